// File: rtl/siso_layer_scheduler_if.sv
// Control/read-port bundle between the decoder top, the layer scheduler and the SISO row unit.
interface siso_layer_scheduler_if #(
    parameter int unsigned ADDRWIDTH = 5,
    parameter int unsigned LAYERBITS = 1,
    parameter int unsigned ITERBITS  = 4
);
    logic                 start;
    logic                 wren;
    logic                 syndrome_ok;
    logic [LAYERBITS-1:0] rdlayer;
    logic [ADDRWIDTH-1:0] rdaddress;
    logic                 rden_LLR;
    logic                 rden_E;
    logic                 busy;
    logic                 done;
    logic [ITERBITS-1:0]  iter_count;
    logic                 early_term;

    modport master (
        output start, wren, syndrome_ok,
        input  rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count, early_term
    );

    modport slave (
        input  start, wren, syndrome_ok,
        output rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count, early_term
    );
endinterface

// File: rtl/siso_layer_scheduler.sv
// Layer/iteration read sequencer for the SISO row unit; drains write-backs between layers.
// Optional early termination on syndrome_ok is enabled by defining SISO_SCHED_EARLYTERM_EN.
module siso_layer_scheduler #(
    parameter int unsigned ADDRWIDTH = 5,
    parameter int unsigned ADDRDEPTH = 20,
    parameter int unsigned LAYERS    = 2,
    parameter int unsigned LAYERBITS = 1,
    parameter int unsigned MAXITER   = 8,
    parameter int unsigned ITERBITS  = 4
) (
    input logic                   clk,
    input logic                   rst,
    siso_layer_scheduler_if.slave bus
);
    localparam int unsigned          CNTW       = ADDRWIDTH + 1;
    localparam logic [ADDRWIDTH-1:0] ADDR_LAST  = ADDRWIDTH'(ADDRDEPTH - 1);
    localparam logic [LAYERBITS-1:0] LAYER_LAST = LAYERBITS'(LAYERS - 1);
    localparam logic [ITERBITS-1:0]  ITER_MAX   = ITERBITS'(MAXITER);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t               state;
    logic [ADDRWIDTH-1:0] addr;
    logic [LAYERBITS-1:0] layer;
    logic [ITERBITS-1:0]  iter;
    logic                 et;
    logic [CNTW-1:0]      outstanding;
    logic [CNTW-1:0]      outstanding_nxt_c;
    logic [ITERBITS-1:0]  iter_inc_c;
    logic                 syn_c;

`ifdef SISO_SCHED_EARLYTERM_EN
    assign syn_c = bus.syndrome_ok;
`else
    logic syndrome_unused;
    assign syndrome_unused = bus.syndrome_ok;
    assign syn_c           = 1'b0;
`endif

    assign iter_inc_c = iter + ITERBITS'(1);

    // Rows in flight: +1 per issued read, -1 per write-back, never below zero
    always_comb begin
        outstanding_nxt_c = outstanding;
        if (bus.rden_LLR && !bus.wren) begin
            outstanding_nxt_c = outstanding + CNTW'(1);
        end else if (!bus.rden_LLR && bus.wren && (outstanding != '0)) begin
            outstanding_nxt_c = outstanding - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            addr           <= '0;
            layer          <= '0;
            iter           <= '0;
            et             <= 1'b0;
            outstanding    <= '0;
            bus.rdlayer    <= '0;
            bus.rdaddress  <= '0;
            bus.rden_LLR   <= 1'b0;
            bus.rden_E     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.iter_count <= '0;
            bus.early_term <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt_c;

            // Outputs present the sequencer state one cycle later
            bus.rdlayer    <= layer;
            bus.rdaddress  <= addr;
            bus.rden_LLR   <= (state == ISSUE);
            bus.rden_E     <= (state == ISSUE) && (iter != '0);
            bus.busy       <= (state == ISSUE) || (state == DRAIN);
            bus.done       <= (state == FIN);
            bus.iter_count <= iter;
            bus.early_term <= et;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ISSUE;
                        addr  <= '0;
                        layer <= '0;
                        iter  <= '0;
                        et    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (addr == ADDR_LAST) begin
                        addr  <= '0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ADDRWIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Leave as soon as the final write-back lands, so the next read follows one cycle later
                    if (outstanding_nxt_c == '0) begin
                        if (layer != LAYER_LAST) begin
                            layer <= layer + LAYERBITS'(1);
                            state <= ISSUE;
                        end else begin
                            iter <= iter_inc_c;
                            if ((iter_inc_c == ITER_MAX) || syn_c) begin
                                et    <= syn_c;
                                state <= FIN;
                            end else begin
                                layer <= '0;
                                state <= ISSUE;
                            end
                        end
                    end
                end
                FIN: begin
                    layer <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Scoreboard bench for siso_layer_scheduler: reference read list and closed-form timing per decode job.
module tb_siso_layer_scheduler;
    localparam int unsigned ADDRWIDTH = 5;
    localparam int unsigned ADDRDEPTH = 20;
    localparam int unsigned LAYERS    = 2;
    localparam int unsigned LAYERBITS = 1;
    localparam int unsigned MAXITER   = 4;
    localparam int unsigned ITERBITS  = 4;
`ifdef SISO_SCHED_EARLYTERM_EN
    localparam bit ET_EN = 1'b1;
`else
    localparam bit ET_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    siso_layer_scheduler_if #(.ADDRWIDTH(ADDRWIDTH), .LAYERBITS(LAYERBITS), .ITERBITS(ITERBITS)) bus ();

    siso_layer_scheduler #(
        .ADDRWIDTH(ADDRWIDTH), .ADDRDEPTH(ADDRDEPTH), .LAYERS(LAYERS),
        .LAYERBITS(LAYERBITS), .MAXITER(MAXITER), .ITERBITS(ITERBITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { int layer; int addr; bit e; bit first; bit last; } rd_t;
    typedef struct { int iters; bit et; int cyc; } fin_t;
    typedef struct { int cyc; bit last; } due_t;

    rd_t  rd_q[$];
    fin_t fin_q[$];
    due_t due_q[$];
    rd_t  mon_r;
    fin_t mon_f;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int lat = 13;
    int hold_burst = -1;
    int hold_extra = 0;
    int et_bursts = 0;
    int bursts_done = 0;
    int burst_idx = 0;
    int exp_next = 0;
    int prev_rd = 0;
    bit spur_wren = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Row-unit model: returns one wren per read after the configured latency
    initial begin
        bus.wren        = 1'b0;
        bus.syndrome_ok = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.wren = 1'b0;
            if (due_q.size() > 0 && due_q[0].cyc <= cyc) begin
                bus.wren = 1'b1;
                if (due_q[0].last) begin
                    bursts_done++;
                    exp_next = cyc + 2;
                end
                void'(due_q.pop_front());
            end else if (spur_wren) begin
                bus.wren  = 1'b1;
                spur_wren = 1'b0;
            end
            bus.syndrome_ok = (et_bursts != 0) && (bursts_done == et_bursts);
        end
    end

    // Monitor: pops expected reads and completions as the DUT presents them
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rden_LLR) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_read: rden_LLR=1 at cycle %0d, required 0", cyc);
                end else begin
                    mon_r = rd_q.pop_front();
                    check("read_cycle", cyc, mon_r.first ? exp_next : prev_rd + 1);
                    check("rdlayer", int'(bus.rdlayer), mon_r.layer);
                    check("rdaddress", int'(bus.rdaddress), mon_r.addr);
                    check("rden_E", int'(bus.rden_E), int'(mon_r.e));
                    check("busy_during_read", int'(bus.busy), 1);
                    prev_rd = cyc;
                    due_q.push_back('{cyc + lat + ((mon_r.last && burst_idx == hold_burst) ? hold_extra : 0),
                                      mon_r.last});
                    if (mon_r.last) burst_idx++;
                end
            end else begin
                check("rden_E_without_read", int'(bus.rden_E), 0);
            end
            if (bus.done) begin
                if (fin_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
                end else begin
                    mon_f = fin_q.pop_front();
                    check("done_after_drain", cyc, exp_next);
                    check("done_cycle_total", cyc, mon_f.cyc);
                    check("iter_count", int'(bus.iter_count), mon_f.iters);
                    check("early_term", int'(bus.early_term), int'(mon_f.et));
                    check("busy_at_done", int'(bus.busy), 0);
                    check("reads_left_at_done", rd_q.size(), 0);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rdlayer"}, int'(bus.rdlayer), 0);
        check({tag, "_rdaddress"}, int'(bus.rdaddress), 0);
        check({tag, "_rden_LLR"}, int'(bus.rden_LLR), 0);
        check({tag, "_rden_E"}, int'(bus.rden_E), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_iter_count"}, int'(bus.iter_count), 0);
        check({tag, "_early_term"}, int'(bus.early_term), 0);
    endtask

    task automatic push_reads(input int n_it);
        for (int it = 0; it < n_it; it++)
            for (int l = 0; l < int'(LAYERS); l++)
                for (int a = 0; a < int'(ADDRDEPTH); a++)
                    rd_q.push_back('{l, a, it != 0, a == 0, a == int'(ADDRDEPTH) - 1});
    endtask

    // One codeword: l = write-back latency, hb/hx = burst whose last wren is held and by how much
    task automatic run_job(input int l, input int hb, input int hx, input bit ss, input bit sw, input int et_iter);
        int n_it;
        int s;
        int b;
        int t;
        bit et;
        lat         = l;
        hold_burst  = hb;
        hold_extra  = hx;
        burst_idx   = 0;
        bursts_done = 0;
        et_bursts   = et_iter * int'(LAYERS);
        if (ET_EN && et_iter > 0) begin
            n_it = et_iter;
            et   = 1'b1;
        end else begin
            n_it = int'(MAXITER);
            et   = 1'b0;
        end
        b = n_it * int'(LAYERS);
        if (sw) begin
            spur_wren = 1'b1;
            repeat (3) @(posedge clk);
        end
        push_reads(n_it);
        @(posedge clk);
        #2;
        s         = cyc;
        bus.start = 1'b1;
        exp_next  = s + 2;
        fin_q.push_back('{n_it, et, s + 2 + b * (int'(ADDRDEPTH) + l + 1) + ((hb >= 0 && hb < b) ? hx : 0)});
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        if (ss) begin
            repeat (1 + int'($urandom_range(0, 30))) @(posedge clk);
            #2;
            check("busy_at_spurious_start", int'(bus.busy), 1);
            bus.start = 1'b1;
            @(posedge clk);
            #2;
            bus.start = 1'b0;
        end
        t = 0;
        while (fin_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (fin_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL job_timeout: no done within %0d cycles of start at cycle %0d", t, s);
            fin_q.delete();
            rd_q.delete();
            due_q.delete();
        end
        repeat (3) @(posedge clk);
        et_bursts = 0;
    endtask

    // Async reset in the middle of the first burst, then confirm the block stays idle
    task automatic reset_test();
        int s;
        lat         = 13;
        hold_burst  = -1;
        burst_idx   = 0;
        bursts_done = 0;
        et_bursts   = 0;
        push_reads(int'(MAXITER));
        @(posedge clk);
        #2;
        s         = cyc;
        bus.start = 1'b1;
        exp_next  = s + 2;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        while (cyc < s + 9) begin
            @(posedge clk);
            #2;
        end
        check("addr_before_reset", int'(bus.rdaddress), 7);
        check("rden_before_reset", int'(bus.rden_LLR), 1);
        rst = 1'b0;
        rd_q.delete();
        due_q.delete();
        fin_q.delete();
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("idle_after_reset_rden", int'(bus.rden_LLR), 0);
        check("idle_after_reset_busy", int'(bus.busy), 0);
    endtask

    initial begin
        int l;
        int hb;
        int hx;
        int ei;
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset_state");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_job(13, -1, 0, 1'b0, 1'b0, 0);
        run_job(13, 0, 10, 1'b0, 1'b0, 0);
        run_job(1, -1, 0, 1'b0, 1'b0, 0);
        run_job(13, -1, 0, 1'b1, 1'b1, 0);
        run_job(13, -1, 0, 1'b0, 1'b0, 3);
        reset_test();

        for (int i = 0; i < 6; i++) begin
            l  = int'($urandom_range(1, 16));
            hb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LAYERS * MAXITER - 1)) : -1;
            hx = int'($urandom_range(1, 12));
            ei = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, MAXITER - 1)) : 0;
            run_job(l, hb, hx, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ei);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
